uart_mem_bridge: RTL and testbench

// - Host-side consumer of the uart_comm byte FIFO interface. Parses command packets from
//   the receive FIFO, performs one 32-bit memory read or write, and pushes the response

---
 rtl/uart_mem_bridge_pkg.sv | 16 +
 rtl/uart_mem_bridge_if.sv | 27 ++
 rtl/uart_bridge_txq.sv | 56 +++++
 rtl/uart_mem_bridge.sv | 135 +++++++++++++
 tb/tb_uart_mem_bridge.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mem_bridge_pkg.sv
// Shared constants and FSM encoding for the UART-to-memory command bridge.
package uart_mem_bridge_pkg;

  localparam logic [7:0] OPC_WRITE = 8'h01;
  localparam logic [7:0] OPC_READ  = 8'h02;

  typedef enum logic [5:0] {
    StIdle = 6'b000001,
    StOpc  = 6'b000010,
    StAddr = 6'b000100,
    StData = 6'b001000,
    StMem  = 6'b010000,
    StResp = 6'b100000
  } state_e;

endpackage

// File: rtl/uart_mem_bridge_if.sv
// Byte FIFO (rx/tx) and memory request signals between the bridge and its neighbours.
interface uart_mem_bridge_if;

  logic        rx_avail;
  logic [7:0]  rx_byte;
  logic        rx_pop;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        tx_push;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  rx_avail, rx_byte, tx_ready, mem_rdata, mem_ack,
    output rx_pop, tx_byte, tx_push, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_avail, rx_byte, tx_ready, mem_rdata, mem_ack,
    input  rx_pop, tx_byte, tx_push, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/uart_bridge_txq.sv
// Response queue: loads 1 or 4 bytes and pushes them LSB first, never on adjacent cycles.
module uart_bridge_txq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_four,
  input  logic [31:0] i_data,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_push,
  output logic        o_done
);

  logic [31:0] r_shift;
  logic [2:0]  r_left;
  logic        r_push;
  logic [7:0]  r_byte;
  logic        r_done;

  logic [31:0] w_shift;
  logic [2:0]  w_left;
  logic        w_fire;

  // A load may fire in the same cycle so the first push follows the load by one cycle.
  always_comb begin
    w_shift = i_load ? i_data : r_shift;
    w_left  = i_load ? (i_four ? 3'd4 : 3'd1) : r_left;
    w_fire  = (w_left != 3'd0) && i_tx_ready && !r_push;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_left  <= '0;
      r_push  <= 1'b0;
      r_byte  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_push <= w_fire;
      r_done <= w_fire && (w_left == 3'd1);
      if (w_fire) begin
        r_byte  <= w_shift[7:0];
        r_shift <= {8'h00, w_shift[31:8]};
        r_left  <= w_left - 3'd1;
      end else begin
        r_shift <= w_shift;
        r_left  <= w_left;
      end
    end
  end

  assign o_tx_byte = r_byte;
  assign o_tx_push = r_push;
  assign o_done    = r_done;

endmodule

// File: rtl/uart_mem_bridge.sv
// Parses host command packets from the rx FIFO, performs one 32-bit memory access and
// queues the response bytes to the tx FIFO.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ACK_BYTE       = 8'hA5,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_mem_bridge_if.master bus,
  output logic              o_busy,
  output logic              o_timeout_err
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  state_e      r_state, w_state;
  logic        r_pop;
  logic [7:0]  r_byte;
  logic [1:0]  r_idx;
  logic [CntW-1:0] r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req;
  logic        r_tmo;

  logic        w_collect;
  logic        w_tmo;
  logic        w_take;
  logic        w_ack;
  logic        w_load;
  logic        w_four;
  logic [31:0] w_load_data;
  logic        w_txq_done;

  assign w_collect = (r_state == StAddr) || (r_state == StData);
  assign w_tmo     = w_collect && (r_cnt == CntMax);
  // The byte is latched on the edge that raises rx_pop and consumed during the pop cycle.
  assign w_take    = bus.rx_avail && !r_pop && !w_tmo &&
                     ((r_state == StIdle) || w_collect);
  assign w_ack     = r_req && bus.mem_ack;

  always_comb begin
    w_state     = r_state;
    w_load      = 1'b0;
    w_four      = 1'b0;
    w_load_data = 32'h0;
    unique case (r_state)
      StIdle: if (r_pop) w_state = StOpc;
      StOpc: begin
        if (r_byte == OPC_WRITE || r_byte == OPC_READ) begin
          w_state = StAddr;
        end else begin
          w_state     = StResp;
          w_load      = 1'b1;
          w_load_data = {24'h0, ERR_BYTE};
        end
      end
      StAddr: begin
        if (w_tmo) w_state = StIdle;
        else if (r_pop && r_idx == 2'd3) w_state = r_we ? StData : StMem;
      end
      StData: begin
        if (w_tmo) w_state = StIdle;
        else if (r_pop && r_idx == 2'd3) w_state = StMem;
      end
      StMem: begin
        if (w_ack) begin
          w_state     = StResp;
          w_load      = 1'b1;
          w_four      = !r_we;
          w_load_data = r_we ? {24'h0, ACK_BYTE} : bus.mem_rdata;
        end
      end
      StResp: if (w_txq_done) w_state = StIdle;
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_pop   <= 1'b0;
      r_byte  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_req   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pop   <= w_take;
      r_tmo   <= w_tmo;
      if (w_take) r_byte <= bus.rx_byte;
      if (r_state == StOpc) begin
        r_we  <= (r_byte == OPC_WRITE);
        r_idx <= '0;
      end
      if (r_pop && w_collect) r_idx <= r_idx + 2'd1;
      if (r_pop && r_state == StAddr) r_addr  <= {r_byte, r_addr[31:8]};
      if (r_pop && r_state == StData) r_wdata <= {r_byte, r_wdata[31:8]};
      if (w_tmo) r_idx <= '0;
      r_cnt <= (w_collect && !w_tmo && !w_take) ? r_cnt + CntW'(1) : '0;
      // Entry cycle raises the request; the ack edge drops it.
      r_req <= (r_state == StMem) && !w_ack;
    end
  end

  uart_bridge_txq u_txq (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_four     (w_four),
    .i_data     (w_load_data),
    .i_tx_ready (bus.tx_ready),
    .o_tx_byte  (bus.tx_byte),
    .o_tx_push  (bus.tx_push),
    .o_done     (w_txq_done)
  );

  assign bus.rx_pop    = r_pop;
  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign o_busy        = (r_state != StIdle);
  assign o_timeout_err = r_tmo;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench: FIFO and memory models around the bridge, checked with immediate assertions.
module tb_uart_mem_bridge;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic tmo;

  always #5 clk = ~clk;

  uart_mem_bridge_if bus();

  uart_mem_bridge #(
    .TIMEOUT_CYCLES (64),
    .ACK_BYTE       (8'hA5),
    .ERR_BYTE       (8'hEE)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .bus           (bus),
    .o_busy        (busy),
    .o_timeout_err (tmo)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  txs[$];
  int          ack_delay = 0;
  logic [31:0] rdata_val = 32'h0;

  int          cyc = 0;
  int          req_cycles = 0;
  int          req_count = 0;
  int          req_len = 0;
  int          ack_count = 0;
  int          consec = 0;
  int          last_pop_cyc = 0;
  int          req_rise_cyc = 0;
  int          ack_cyc = 0;
  int          first_push_cyc = 0;
  int          tmo_count = 0;
  int          tmo_cyc = 0;
  logic        busy_at_tmo = 1'b0;
  logic        wait_push = 1'b0;
  logic        prev_push = 1'b0;
  logic        stable = 1'b0;
  logic        rec_we = 1'b0;
  logic [31:0] rec_addr = 32'h0;
  logic [31:0] rec_wdata = 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.rx_pop && rxq.size() != 0) void'(rxq.pop_front());
  end

  // FIFO head, memory responder and monitors, all updated away from the active edge.
  always @(negedge clk) begin
    bus.rx_avail  <= (rxq.size() != 0);
    bus.rx_byte   <= (rxq.size() != 0) ? rxq[0] : 8'h00;
    bus.mem_rdata <= rdata_val;
    bus.mem_ack   <= bus.mem_req && (req_cycles == ack_delay);
    req_cycles    <= bus.mem_req ? req_cycles + 1 : 0;
    if (bus.mem_req && req_cycles == 0) begin
      req_count    <= req_count + 1;
      rec_addr     <= bus.mem_addr;
      rec_we       <= bus.mem_we;
      rec_wdata    <= bus.mem_wdata;
      req_rise_cyc <= cyc;
      stable       <= 1'b1;
    end else if (bus.mem_req && (bus.mem_addr != rec_addr || bus.mem_we != rec_we ||
                                 bus.mem_wdata != rec_wdata)) begin
      stable <= 1'b0;
    end
    if (bus.mem_req && req_cycles == ack_delay) begin
      ack_count <= ack_count + 1;
      req_len   <= req_cycles + 1;
      ack_cyc   <= cyc;
      wait_push <= 1'b1;
    end
    if (bus.rx_pop) last_pop_cyc <= cyc;
    if (bus.tx_push) begin
      txs.push_back(bus.tx_byte);
      if (prev_push) consec <= consec + 1;
      if (wait_push) begin
        first_push_cyc <= cyc;
        wait_push      <= 1'b0;
      end
    end
    prev_push <= bus.tx_push;
    if (tmo) begin
      tmo_count   <= tmo_count + 1;
      tmo_cyc     <= cyc;
      busy_at_tmo <= busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || rxq.size() != 0 || bus.tx_push) && n < 500) begin
      tick();
      n++;
    end
    check(tag, 32'(n < 500), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc0;
    int b;
    int t0;
    int a0;
    int n;

    rst          = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    tick();
    check("rst_rx_pop",  32'(bus.rx_pop), 32'd0);
    check("rst_tx_push", 32'(bus.tx_push), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we",  32'(bus.mem_we), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_tmo",     32'(tmo), 32'd0);
    check("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
    check("rst_addr",    bus.mem_addr, 32'd0);
    check("rst_wdata",   bus.mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // WRITE 0x8000_0010 <- 0xDEAD_BEEF
    rc0 = req_count; b = txs.size(); ack_delay = 2;
    send(8'h01); send(8'h10); send(8'h00); send(8'h00); send(8'h80);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    wait_idle("wr_done");
    check("wr_req_count", 32'(req_count - rc0), 32'd1);
    check("wr_we",        32'(rec_we), 32'd1);
    check("wr_addr",      rec_addr, 32'h8000_0010);
    check("wr_wdata",     rec_wdata, 32'hDEAD_BEEF);
    check("wr_stable",    32'(stable), 32'd1);
    check("wr_push_cnt",  32'(txs.size() - b), 32'd1);
    check("wr_ack_byte",  32'(txs[b]), 32'h0000_00A5);
    check("wr_pop_to_req", 32'(req_rise_cyc - last_pop_cyc), 32'd2);
    check("wr_ack_to_push", 32'(first_push_cyc - ack_cyc), 32'd1);

    // READ 0x4 with ack delayed 5 cycles
    rc0 = req_count; b = txs.size(); ack_delay = 5; rdata_val = 32'h1234_5678;
    send(8'h02); send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    wait_idle("rd_done");
    check("rd_req_count", 32'(req_count - rc0), 32'd1);
    check("rd_req_len",   32'(req_len), 32'd6);
    check("rd_we",        32'(rec_we), 32'd0);
    check("rd_addr",      rec_addr, 32'h0000_0004);
    check("rd_stable",    32'(stable), 32'd1);
    check("rd_push_cnt",  32'(txs.size() - b), 32'd4);
    check("rd_b0", 32'(txs[b]),     32'h78);
    check("rd_b1", 32'(txs[b + 1]), 32'h56);
    check("rd_b2", 32'(txs[b + 2]), 32'h34);
    check("rd_b3", 32'(txs[b + 3]), 32'h12);
    check("rd_no_consec", 32'(consec), 32'd0);

    // Unknown opcode, then a normal READ with a same-cycle ack
    rc0 = req_count; b = txs.size();
    send(8'h7F);
    wait_idle("err_done");
    check("err_no_req",   32'(req_count - rc0), 32'd0);
    check("err_push_cnt", 32'(txs.size() - b), 32'd1);
    check("err_byte",     32'(txs[b]), 32'h0000_00EE);
    b = txs.size(); ack_delay = 0; rdata_val = 32'hCAFE_F00D;
    send(8'h02); send(8'h08); send(8'h00); send(8'h00); send(8'h00);
    wait_idle("rd2_done");
    check("rd2_req_count", 32'(req_count - rc0), 32'd1);
    check("rd2_req_len",   32'(req_len), 32'd1);
    check("rd2_addr",      rec_addr, 32'h0000_0008);
    check("rd2_b0", 32'(txs[b]),     32'h0D);
    check("rd2_b3", 32'(txs[b + 3]), 32'hCA);

    // Timeout after two address bytes
    rc0 = req_count; b = txs.size(); t0 = tmo_count;
    send(8'h02); send(8'h04); send(8'h00);
    n = 0;
    while (tmo_count == t0 && n < 300) begin
      tick();
      n++;
    end
    check("to_seen", 32'(n < 300), 32'd1);
    check("to_latency", 32'(tmo_cyc - last_pop_cyc), 32'd64);
    check("to_busy", 32'(busy_at_tmo), 32'd0);
    repeat (10) tick();
    check("to_single_pulse", 32'(tmo_count - t0), 32'd1);
    check("to_no_push", 32'(txs.size() - b), 32'd0);
    check("to_no_req",  32'(req_count - rc0), 32'd0);
    check("to_idle",    32'(busy), 32'd0);

    // tx_ready stalled across a READ response
    bus.tx_ready = 1'b0;
    b = txs.size(); a0 = ack_count; ack_delay = 1; rdata_val = 32'hA1B2_C3D4;
    send(8'h02); send(8'h20); send(8'h00); send(8'h00); send(8'h00);
    n = 0;
    while (ack_count == a0 && n < 100) begin
      tick();
      n++;
    end
    check("st_ack_seen", 32'(n < 100), 32'd1);
    repeat (100) tick();
    check("st_no_push", 32'(txs.size() - b), 32'd0);
    check("st_busy",    32'(busy), 32'd1);
    bus.tx_ready = 1'b1;
    wait_idle("st_done");
    check("st_push_cnt", 32'(txs.size() - b), 32'd4);
    check("st_b0", 32'(txs[b]),     32'hD4);
    check("st_b1", 32'(txs[b + 1]), 32'hC3);
    check("st_b2", 32'(txs[b + 2]), 32'hB2);
    check("st_b3", 32'(txs[b + 3]), 32'hA1);
    check("st_no_consec", 32'(consec), 32'd0);

    // Reset while a request is outstanding, then a clean WRITE
    ack_delay = 1000;
    send(8'h01); send(8'h00); send(8'h01); send(8'h00); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    n = 0;
    while (!bus.mem_req && n < 100) begin
      tick();
      n++;
    end
    check("rs_req_seen", 32'(n < 100), 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rs_req_drop", 32'(bus.mem_req), 32'd0);
    check("rs_busy",     32'(busy), 32'd0);
    check("rs_tx_push",  32'(bus.tx_push), 32'd0);
    rst = 1'b0;
    ack_delay = 0;
    tick();
    rc0 = req_count; b = txs.size();
    send(8'h01); send(8'h40); send(8'h00); send(8'h00); send(8'h00);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    wait_idle("rs_wr_done");
    check("rs_wr_req_count", 32'(req_count - rc0), 32'd1);
    check("rs_wr_we",    32'(rec_we), 32'd1);
    check("rs_wr_addr",  rec_addr, 32'h0000_0040);
    check("rs_wr_wdata", rec_wdata, 32'h1234_5678);
    check("rs_wr_ack",   32'(txs[b]), 32'h0000_00A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
